girl_sprite_fetch: RTL
======================

// Module: girl_sprite_fetch
// PURPOSE
//  Upstream feeder for the girl palette LUT. Per VGA pixel: box test against the sprite position,
//  ROM address (frame/row/column, optional horizontal mirror), pipeline alignment with the
//  synchronous sprite ROM, and transparency flagging. Emits a 4-bit palette_index + sprite_on to
//  the palette LUT / colour mapper; also owns the walk-cycle animation frame counter.
// PARAMETERS
//  SPRITE_W     32  sprite width in pixels (power of 2)
//  SPRITE_H     32  sprite height in pixels (power of 2)
//  FRAMES       4   walk-cycle frames stored back-to-back in the ROM (power of 2)
//  FRAME_HOLD   8   video frames each animation frame is displayed
//  TRANSP_IDX   0   palette index treated as transparent (background key colour)
//  ADDR_W       $clog2(FRAMES*SPRITE_W*SPRITE_H) = 12   ROM address width
// PORTS
//  Clk            in   1       pixel clock
//  Reset          in   1       asynchronous, active-high
//  DrawX          in   10      current pixel column from VGA controller
//  DrawY          in   10      current pixel row from VGA controller
//  frame_start    in   1       one-Clk pulse at start of vertical blank
//  sprite_x       in   10      sprite top-left column
//  sprite_y       in   10      sprite top-left row
//  facing_left    in   1       1 = mirror horizontally
//  walking        in   1       1 = advance walk cycle
//  rom_addr       out  ADDR_W  registered address to sprite ROM
//  rom_data       in   4       ROM output; valid one Clk after rom_addr
//  palette_index  out  4       registered index to palette LUT
//  sprite_on      out  1       1 = in box and index != TRANSP_IDX
//  anim_frame     out  $clog2(FRAMES)  current walk frame
// BEHAVIOUR
//  Reset (async, any time): rom_addr=0, palette_index=0, sprite_on=0, anim_frame=0, hold_cnt=0,
//   all pipeline valid flags=0. First legal output 3 edges after Reset deasserts.
//  Stage A (edge k): rx=DrawX-sprite_x, ry=DrawY-sprite_y; in_box = DrawX>=sprite_x &&
//   DrawX<sprite_x+SPRITE_W (11-bit add, no wrap; same for Y). col = facing_left ? W-1-rx : rx.
//   rom_addr <= in_box ? {anim_frame, ry[log2H-1:0], col[log2W-1:0]} : 0; vA <= in_box.
//  Stage B (edge k+1): ROM registers rom_data; block delays vA -> vB.
//  Stage C (edge k+2): palette_index <= vB ? rom_data : TRANSP_IDX; sprite_on <= vB &&
//   (rom_data != TRANSP_IDX). Total latency: inputs at edge k appear on outputs after edge k+2.
//  Out-of-box pixels always yield palette_index=TRANSP_IDX, sprite_on=0, regardless of rom_data.
//  Sprite partly off-screen (sprite_x+W>639 or >1023): only on-screen columns match; no wrap.
//  Animation FSM (WALK/IDLE, encoded by walking):
//   walking=0: hold_cnt<=0, anim_frame<=0 on next Clk (stand pose, frame 0).
//   walking=1 & frame_start: if hold_cnt==FRAME_HOLD-1 {hold_cnt<=0; anim_frame<=anim_frame+1
//    mod FRAMES} else hold_cnt<=hold_cnt+1. No change on cycles without frame_start.
//   walking falling and frame_start same cycle: walking=0 wins (reset to 0).
//   anim_frame only changes on frame_start or walking=0, so no mid-line tearing while walking.
//  facing_left, sprite_x/y sampled every pixel; callers update them during vblank.
// TESTING
//  1 Reset mid-stream with sprite_on=1 -> all outputs 0 same cycle; first valid 3 edges after release.
//  2 sprite_x=100,y=50,facing_left=0, DrawX=100,DrawY=50 -> rom_addr=0x000; DrawX=131,DrawY=51 ->
//    0x03F; DrawX=132 -> rom_addr=0, sprite_on=0 3 edges later.
//  3 facing_left=1, DrawX=100,DrawY=50 -> rom_addr=0x01F; rom_data=5 -> palette_index=5,
//    sprite_on=1 exactly after edge k+2.
//  4 in-box pixel with rom_data=0 -> palette_index=0, sprite_on=0; out-of-box with rom_data=9 -> 0/0.
//  5 walking=1, 40 frame_start pulses -> anim_frame steps 0,1,2,3,0,... every 8 pulses, back to 1
//    after pulse 40; drop walking -> anim_frame=0 next Clk.
//  6 sprite_x=620 -> DrawX 620..639 in box, DrawX=0 row never matches (no wrap).

Source files
------------

// File: rtl/girl_sprite_fetch_if.sv
// Pixel/sprite bus between the VGA side, the sprite ROM and the girl sprite fetcher.
// master = VGA controller + game logic + ROM side, slave = the fetcher itself.
interface girl_sprite_fetch_if #(
  parameter int ADDR_W  = 12,
  parameter int FRAME_W = 2
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               frame_start;
  logic [9:0]         sprite_x;
  logic [9:0]         sprite_y;
  logic               facing_left;
  logic               walking;
  logic [ADDR_W-1:0]  rom_addr;
  logic [3:0]         rom_data;
  logic [3:0]         palette_index;
  logic               sprite_on;
  logic [FRAME_W-1:0] anim_frame;

  modport master (
    output DrawX, DrawY, frame_start, sprite_x, sprite_y, facing_left, walking, rom_data,
    input  rom_addr, palette_index, sprite_on, anim_frame
  );

  modport slave (
    input  DrawX, DrawY, frame_start, sprite_x, sprite_y, facing_left, walking, rom_data,
    output rom_addr, palette_index, sprite_on, anim_frame
  );
endinterface

// File: rtl/girl_sprite_fetch.sv
// Girl sprite fetcher: box test + ROM addressing, 3-stage alignment with the synchronous ROM,
// transparency flagging, and the walk-cycle frame counter. Free-running pipeline, no backpressure:
// every pixel presented at edge k yields palette_index/sprite_on after edge k+2.
module girl_sprite_fetch #(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int FRAMES     = 4,
  parameter int FRAME_HOLD = 8,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  girl_sprite_fetch_if.slave bus,
  output logic              o_dbg_walk
);
  localparam int LOG2W   = $clog2(SPRITE_W);
  localparam int LOG2H   = $clog2(SPRITE_H);
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_e;

  walk_state_e        r_state;
  logic [FRAME_W-1:0] r_anim_frame;
  logic [HOLD_W-1:0]  r_hold_cnt;

  logic [10:0]        w_x_end;
  logic [10:0]        w_y_end;
  logic               w_in_x;
  logic               w_in_y;
  logic               w_in_box;
  logic [LOG2W-1:0]   w_rx;
  logic [LOG2W-1:0]   w_col;
  logic [LOG2H-1:0]   w_ry;
  logic [ADDR_W-1:0]  w_addr;

  logic               r_va;
  logic               r_vb;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [3:0]         r_pal;
  logic               r_on;

  // 11-bit compare so a sprite hanging past column 1023 never wraps onto column 0.
  assign w_x_end  = {1'b0, bus.sprite_x} + 11'(SPRITE_W);
  assign w_y_end  = {1'b0, bus.sprite_y} + 11'(SPRITE_H);
  assign w_in_x   = ({1'b0, bus.DrawX} >= {1'b0, bus.sprite_x}) && ({1'b0, bus.DrawX} < w_x_end);
  assign w_in_y   = ({1'b0, bus.DrawY} >= {1'b0, bus.sprite_y}) && ({1'b0, bus.DrawY} < w_y_end);
  assign w_in_box = w_in_x && w_in_y;

  assign w_rx   = bus.DrawX[LOG2W-1:0] - bus.sprite_x[LOG2W-1:0];
  assign w_ry   = bus.DrawY[LOG2H-1:0] - bus.sprite_y[LOG2H-1:0];
  // W-1-rx is the bitwise complement because the width is a power of two.
  assign w_col  = bus.facing_left ? ~w_rx : w_rx;
  assign w_addr = {r_anim_frame, w_ry, w_col};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rom_addr <= '0;
      r_va       <= 1'b0;
      r_vb       <= 1'b0;
      r_pal      <= 4'(TRANSP_IDX);
      r_on       <= 1'b0;
    end else begin
      r_rom_addr <= w_in_box ? w_addr : '0;
      r_va       <= w_in_box;
      r_vb       <= r_va;
      r_pal      <= r_vb ? bus.rom_data : 4'(TRANSP_IDX);
      r_on       <= r_vb && (bus.rom_data != 4'(TRANSP_IDX));
    end
  end

  // Walk cycle only moves on frame_start, so the pose never changes mid-line.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_anim_frame <= '0;
    end else if (!bus.walking) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_anim_frame <= '0;
    end else begin
      r_state <= ST_WALK;
      if (bus.frame_start) begin
        if (r_hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
          r_hold_cnt   <= '0;
          r_anim_frame <= (r_anim_frame == FRAME_W'(FRAMES - 1)) ? '0 : r_anim_frame + 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.rom_addr      = r_rom_addr;
  assign bus.palette_index = r_pal;
  assign bus.sprite_on     = r_on;
  assign bus.anim_frame    = r_anim_frame;
  assign o_dbg_walk        = (r_state == ST_WALK);

endmodule
